// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// The optional PS2_PARITY_CHECK_EN macro is consumed by ps2_keyboard_rx.
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  localparam int VALID_BIT = 15;
  localparam int EXT_BIT   = 9;
  localparam int REL_BIT   = 8;

  function automatic logic [15:0] mk_word(input logic ext, input logic rel,
                                          input logic [7:0] code);
    logic [15:0] w;
    w = 16'h0000;
    w[VALID_BIT] = 1'b1;
    w[EXT_BIT]   = ext;
    w[REL_BIT]   = rel;
    w[7:0]       = code;
    return w;
  endfunction
endpackage

// File: rtl/ps2_fifo.sv
// Key-event FIFO; a read strobe loads the head (or zero when empty) into a
// registered output that holds until the next strobe.
module ps2_fifo #(
  parameter int AW = 4,
  parameter int W  = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          ren_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o
);
  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  logic [W-1:0]  mem_q [2**AW];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, do_pop, do_push;

  always_comb begin
    full    = (cnt_q == DEPTH);
    empty   = (cnt_q == '0);
    do_pop  = ren_i & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push = push_i & (~full | do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rdata_d = rdata_q;
    if (ren_i) rdata_d = empty ? '0 : mem_q[rptr_q];
    ovf_d   = ovf_q | (push_i & ~do_push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ovf_q   <= ovf_d;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push) wptr_q <= wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = rdata_q;
  assign count_o = cnt_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: frames bytes, folds E0/F0 prefixes into
// key-event words and queues them. Define PS2_PARITY_CHECK_EN to drop bad-parity frames.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_AW        = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk_pin,
  input  logic               ps2_dat_pin,
  input  logic               ps2_ren,
  output logic [15:0]        ps2_data_out,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]  csync_q, dsync_q;
  logic        chist_q;
  ps2_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic        ext_q, ext_d, rel_q, rel_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        fe, din, good, push;
  logic [15:0] wdata;

  assign fe  = chist_q & ~csync_q[1];
  assign din = dsync_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    par_d     = par_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    good      = 1'b0;
    push      = 1'b0;
    wdata     = mk_word(ext_q, rel_q, sh_q);
    tmo_d     = (state_q == IDLE || fe) ? '0 : tmo_q + TW'(1);
    case (state_q)
      IDLE: if (fe && !din) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (fe) begin
        sh_d      = {din, sh_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fe) begin
        par_d   = din;
        state_d = STOP;
      end
      STOP: if (fe) begin
`ifdef PS2_PARITY_CHECK_EN
        good = din & (^{sh_q, par_q});
`else
        good = din;
`endif
        state_d = IDLE;
        if (good) begin
          if (sh_q == PS2_EXT)      ext_d = 1'b1;
          else if (sh_q == PS2_REL) rel_d = 1'b1;
          else begin
            push  = 1'b1;
            ext_d = 1'b0;
            rel_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A stalled keyboard must not leave a half frame to swallow the next one.
    if (state_q != IDLE && !fe && tmo_q == TMAX) begin
      state_d = IDLE;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csync_q   <= 2'b11;
      dsync_q   <= 2'b11;
      chist_q   <= 1'b1;
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      csync_q   <= {csync_q[0], ps2_clk_pin};
      dsync_q   <= {dsync_q[0], ps2_dat_pin};
      chist_q   <= csync_q[1];
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      tmo_q     <= tmo_d;
    end
  end

  ps2_fifo #(.AW(FIFO_AW), .W(16)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wdata),
    .ren_i   (ps2_ren),
    .rdata_o (ps2_data_out),
    .count_o (fifo_count),
    .ovf_o   (overflow)
  );
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: queue-based key-event model checked every cycle,
// plus literal expectations at the interesting points.
module tb_ps2_keyboard_rx;
  localparam int HP = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        ren = 1'b0;
  logic [15:0] dout;
  logic [4:0]  cnt;
  logic        ovf;

  ps2_keyboard_rx #(.FIFO_AW(4), .TIMEOUT_CYCLES(200)) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_pin  (ps2_clk),
    .ps2_dat_pin  (ps2_dat),
    .ps2_ren      (ren),
    .ps2_data_out (dout),
    .fifo_count   (cnt),
    .overflow     (ovf)
  );

  always #5 clk = ~clk;

  logic [15:0] mq[$];
  logic [15:0] m_dout = 16'h0;
  logic        m_ovf = 1'b0, m_ext = 1'b0, m_rel = 1'b0;
  int          nvec = 0, nerr = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      if (nerr < 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("count", 32'(cnt), 32'(mq.size()));
    check("overflow", 32'(ovf), 32'(m_ovf));
    check("data_out", 32'(dout), 32'(m_dout));
  end

  task automatic model_reset();
    mq.delete();
    m_dout = 16'h0; m_ovf = 1'b0; m_ext = 1'b0; m_rel = 1'b0;
  endtask

  // A read strobe is serviced before a same-edge push (no bypass).
  task automatic model_edge(input bit rd, input bit has_push, input logic [15:0] w);
    if (rd) m_dout = (mq.size() > 0) ? mq.pop_front() : 16'h0000;
    if (has_push) begin
      if (mq.size() < 16) mq.push_back(w);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic ps2_bit(input logic b, input bit last, input bit rd,
                         input bit has_push, input logic [15:0] w);
    ps2_dat = b;
    repeat (HP/2) @(posedge clk); #1;
    ps2_clk = 1'b0;
    if (last) begin
      repeat (2) @(posedge clk); #1;
      if (rd) ren = 1'b1;
      @(posedge clk); #1;
      ren = 1'b0;
      model_edge(rd, has_push, w);
      repeat (HP-3) @(posedge clk); #1;
    end else begin
      repeat (HP) @(posedge clk); #1;
    end
    ps2_clk = 1'b1;
    repeat (HP/2) @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop, input bit rd);
    logic p, good, hp;
    logic [15:0] w;
    p  = par_ok ? ~^b : ^b;
`ifdef PS2_PARITY_CHECK_EN
    good = stop & par_ok;
`else
    good = stop;
`endif
    hp = 1'b0;
    w  = 16'h0;
    if (good) begin
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_rel = 1'b1;
      else begin
        w  = {1'b1, 5'b0, m_ext, m_rel, b};
        hp = 1'b1;
        m_ext = 1'b0; m_rel = 1'b0;
      end
    end
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0, 1'b0, 1'b0, 16'h0);
    ps2_bit(p, 1'b0, 1'b0, 1'b0, 16'h0);
    ps2_bit(stop, 1'b1, rd, hp, w);
    ps2_dat = 1'b1;
    repeat (HP) @(posedge clk); #1;
  endtask

  task automatic partial(input int nbits);
    ps2_bit(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < nbits; i++) ps2_bit(i[0], 1'b0, 1'b0, 1'b0, 16'h0);
    ps2_dat = 1'b1;
  endtask

  task automatic do_read();
    ren = 1'b1;
    @(posedge clk); #1;
    ren = 1'b0;
    model_edge(1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk); #1;
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_count", 32'(cnt), 32'h0);
    check("reset_ovf", 32'(ovf), 32'h0);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (4) @(posedge clk); #1;

    // 1: single make code
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check("t1_count", 32'(cnt), 32'h1);
    do_read();
    check("t1_dout", 32'(dout), 32'h801C);
    check("t1_count_after", 32'(cnt), 32'h0);

    // 2: extended release folds into one word
    send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    check("t2_prefix_no_push", 32'(cnt), 32'h0);
    send_frame(8'h74, 1'b1, 1'b1, 1'b0);
    check("t2_count", 32'(cnt), 32'h1);
    do_read();
    check("t2_dout", 32'(dout), 32'h8374);

    // 3: empty read, then push+pop on empty FIFO
    do_read();
    check("t3_empty_dout", 32'(dout), 32'h0);
    check("t3_empty_count", 32'(cnt), 32'h0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1);
    check("t3_sim_dout", 32'(dout), 32'h0);
    check("t3_sim_count", 32'(cnt), 32'h1);
    do_read();
    check("t3_sim_read", 32'(dout), 32'h8022);

    // 4: bad parity and bad stop
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
    check("t4_badpar_count", 32'(cnt), 32'h0);
`else
    check("t4_badpar_count", 32'(cnt), 32'h1);
    do_read();
    check("t4_badpar_dout", 32'(dout), 32'h801C);
`endif
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    check("t4_badstop_count", 32'(cnt), 32'h0);

    // 5: overflow
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    check("t5_count", 32'(cnt), 32'd16);
    check("t5_ovf", 32'(ovf), 32'h1);
    for (int i = 1; i <= 16; i++) begin
      do_read();
      check("t5_order", 32'(dout), 32'h8000 + 32'(i));
    end
    check("t5_drained", 32'(cnt), 32'h0);

    // 6a: timeout abandons a partial frame
    partial(4);
    repeat (250) @(posedge clk); #1;
    send_frame(8'h15, 1'b1, 1'b1, 1'b0);
    check("t6_tmo_count", 32'(cnt), 32'h1);
    do_read();
    check("t6_tmo_dout", 32'(dout), 32'h8015);

    // 6b: reset mid-frame
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    partial(3);
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_rst_count", 32'(cnt), 32'h0);
    check("t6_rst_ovf", 32'(ovf), 32'h0);
    repeat (HP) @(posedge clk); #1;
    send_frame(8'h15, 1'b1, 1'b1, 1'b0);
    check("t6_rst_push", 32'(cnt), 32'h1);
    do_read();
    check("t6_rst_dout", 32'(dout), 32'h8015);
    check("t6_rst_ovf_end", 32'(ovf), 32'h0);

    repeat (4) @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
